// File: rtl/clock_divider.sv
// Integer clock divider: registered, glitch-free divided clock with a runtime ratio.
// A new ratio is adopted only on the wrap edge, so a period is never shortened or stretched.
module clock_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] div,
    output logic             out,
    output logic             period_start
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_n_q;
    logic             r_run;
    logic             r_out;
    logic             r_period_start;

    logic [WIDTH-1:0] w_n_eff;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_n_nxt;
    logic [WIDTH-1:0] w_high_nxt;
    logic             w_wrap;

    // Ratios 0 and 1 cannot form a period with both phases, so they run as 2.
    assign w_n_eff = (div < WIDTH'(2)) ? WIDTH'(2) : div;
    assign w_wrap  = (r_cnt == r_n_q - WIDTH'(1));

    // The first edge after reset opens period 0 at cnt = 0 rather than advancing.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_cnt_nxt = r_cnt;
        w_n_nxt   = r_n_q;
        if (r_run) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                w_n_nxt   = w_n_eff;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end
    end

    // ceil(N/2) written so that N = 2^WIDTH-1 cannot overflow.
    assign w_high_nxt = w_n_nxt - (w_n_nxt >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_n_q          <= w_n_eff;
            r_run          <= 1'b0;
            r_out          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_n_q          <= w_n_nxt;
            r_run          <= 1'b1;
            r_out          <= (w_cnt_nxt < w_high_nxt);
            r_period_start <= (w_cnt_nxt == '0);
        end
    end

    assign out          = r_out;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: table of per-cycle vectors plus hand-written
// corner sequences, all checked through an expected-value scoreboard queue.
module tb_clock_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] div;
    logic             out;
    logic             period_start;

    clock_divider #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div          (div),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             rst_n;
        logic [WIDTH-1:0] div;
        logic             exp_out;
        logic             exp_ps;
    } vec_t;

    typedef struct {
        string name;
        logic  exp_out;
        logic  exp_ps;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t sb_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add_vec(input string name, input logic r, input logic [WIDTH-1:0] d,
                                    input logic o, input logic p);
        vec_t v;
        v.name = name; v.rst_n = r; v.div = d; v.exp_out = o; v.exp_ps = p;
        vecs.push_back(v);
    endfunction

    // One vector per character: expected out / period_start after each edge, div held.
    function automatic void add_pat(input string name, input logic [WIDTH-1:0] d,
                                    input string po, input string pp);
        for (int i = 0; i < po.len(); i++)
            add_vec(name, 1'b1, d, po.getc(i) == "1", pp.getc(i) == "1");
    endfunction

    // Drive inputs for the next rising edge and queue what that edge must produce.
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n = v.rst_n;
        div   = v.div;
        e.name = v.name; e.exp_out = v.exp_out; e.exp_ps = v.exp_ps;
        sb_q.push_back(e);
    endtask

    task automatic step(input string name, input logic r, input logic [WIDTH-1:0] d,
                        input logic o, input logic p);
        vec_t v;
        v.name = name; v.rst_n = r; v.div = d; v.exp_out = o; v.exp_ps = p;
        drive(v);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check({sb_e.name, ".out"}, out, sb_e.exp_out);
            check({sb_e.name, ".period_start"}, period_start, sb_e.exp_ps);
        end
    end

    initial begin
        rst_n = 1'b0;
        div   = 32'd2;

        // div = 2, 12 cycles
        add_vec("rst_div2", 1'b0, 32'd2, 1'b0, 1'b0);
        add_pat("div2", 32'd2, "101010101010", "101010101010");
        // div = 4, 10 cycles
        add_vec("rst_div4", 1'b0, 32'd4, 1'b0, 1'b0);
        add_pat("div4", 32'd4, "1100110011", "1000100010");
        // div = 3, 9 cycles
        add_vec("rst_div3", 1'b0, 32'd3, 1'b0, 1'b0);
        add_pat("div3", 32'd3, "110110110", "100100100");
        // div = 5, odd ratio with longer high phase
        add_vec("rst_div5", 1'b0, 32'd5, 1'b0, 1'b0);
        add_pat("div5", 32'd5, "1110011100", "1000010000");
        // div = 0 and div = 1 behave as 2
        add_vec("rst_div0", 1'b0, 32'd0, 1'b0, 1'b0);
        add_pat("div0", 32'd0, "101010", "101010");
        add_pat("div1", 32'd1, "101010", "101010");

        foreach (vecs[i]) drive(vecs[i]);

        // 2 -> 4 changed while cnt = 1, then 4 -> 3 changed while cnt = 1
        step("chg_rst",   1'b0, 32'd2, 1'b0, 1'b0);
        step("chg_a0",    1'b1, 32'd2, 1'b1, 1'b1);
        step("chg_a1",    1'b1, 32'd2, 1'b0, 1'b0);
        step("chg_b0",    1'b1, 32'd4, 1'b1, 1'b1);
        step("chg_b1",    1'b1, 32'd4, 1'b1, 1'b0);
        step("chg_b2",    1'b1, 32'd3, 1'b0, 1'b0);
        step("chg_b3",    1'b1, 32'd3, 1'b0, 1'b0);
        step("chg_c0",    1'b1, 32'd3, 1'b1, 1'b1);
        step("chg_c1",    1'b1, 32'd3, 1'b1, 1'b0);
        step("chg_c2",    1'b1, 32'd3, 1'b0, 1'b0);
        step("chg_d0",    1'b1, 32'd3, 1'b1, 1'b1);

        // one-cycle reset at cnt = 2 with div = 4 aborts the period
        step("mid_rst",   1'b0, 32'd4, 1'b0, 1'b0);
        step("mid_p0",    1'b1, 32'd4, 1'b1, 1'b1);
        step("mid_p1",    1'b1, 32'd4, 1'b1, 1'b0);
        step("mid_p2",    1'b1, 32'd4, 1'b0, 1'b0);
        step("mid_abort", 1'b0, 32'd4, 1'b0, 1'b0);
        step("mid_r0",    1'b1, 32'd4, 1'b1, 1'b1);
        step("mid_r1",    1'b1, 32'd4, 1'b1, 1'b0);
        step("mid_r2",    1'b1, 32'd4, 1'b0, 1'b0);
        step("mid_r3",    1'b1, 32'd4, 1'b0, 1'b0);
        step("mid_r4",    1'b1, 32'd4, 1'b1, 1'b1);

        // maximum ratio: high phase is 2^31 cycles, so out must stay high
        step("max_rst",   1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step("max_p0",    1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            step("max_hi", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        // a ratio change deep inside the long period must not take effect
        for (int i = 0; i < 4; i++)
            step("max_hold", 1'b1, 32'd2, 1'b1, 1'b0);

        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
